// File: rtl/dvp_capture_if.sv
// Pixel word stream between the DVP capture front end and the frame-buffer writer.
// Handshake: the producer raises out_valid with out_data/out_sof/out_eol stable and
// holds all of them unchanged until a clk edge where out_valid && out_ready; that
// edge transfers exactly one word. out_ready may change freely and never depends
// combinationally on out_valid. out_sof/out_eol only mean something while out_valid.
interface dvp_capture_if;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sof;
    logic        out_eol;

    modport master (
        output out_data,
        output out_valid,
        output out_sof,
        output out_eol,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_sof,
        input  out_eol,
        output out_ready
    );
endinterface

// File: rtl/dvp_capture.sv
// DVP pixel capture front end. Oversamples the camera pclk/vsync/href/data with the
// system clock, locks to frame timing once sensor configuration is done, discards a
// number of settling frames, packs byte pairs into 16-bit words and presents them on
// a single-entry valid/ready output with frame/line markers, measured geometry and
// sticky error flags. state_dbg exposes the FSM state for observation.
module dvp_capture #(
    parameter int SKIP_FRAMES = 2,
    parameter int H_PIX       = 640,
    parameter int V_LINES     = 480,
    parameter int CNT_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_done,
    input  logic             cam_pclk,
    input  logic             cam_vsync,
    input  logic             cam_href,
    input  logic [7:0]       cam_data,
    dvp_capture_if.master    out_if,
    output logic             frame_end,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_height,
    output logic [2:0]       err_flags,
    output logic [2:0]       state_dbg
);

    localparam int SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
    localparam logic [SKIP_W-1:0] SKIP_INIT = SKIP_W'(SKIP_FRAMES);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam logic [CNT_W-1:0]  H_PIX_C   = CNT_W'(H_PIX);
    localparam logic [CNT_W-1:0]  V_LINES_C = CNT_W'(V_LINES);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_CFG = 3'd0,
        WAIT_VS  = 3'd1,
        WAIT_SOF = 3'd2,
        SKIP     = 3'd3,
        CAPTURE  = 3'd4
    } state_t;

    // Counters stop at all-ones instead of wrapping so a runaway line or frame
    // still reports a large (and therefore wrong) measurement.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Synchronizer stages. pclk has a third stage so the rising edge can be seen
    // while data/href/vsync are at the same synchronizer depth as pclk.
    logic [2:0] pclk_s;
    logic [1:0] vsync_s;
    logic [1:0] href_s;
    logic [7:0] data_s1;
    logic [7:0] data_s2;

    logic pe;
    logic vsync_now;
    logic href_now;
    logic vs_rise;
    logic vs_fall;
    logic href_fall;

    // Last values of vsync/href taken on a pclk edge, for edge detection.
    logic vs_q;
    logic href_q;

    state_t            state;
    logic [SKIP_W-1:0] skip_cnt;
    logic              sof_pending;
    logic              phase;
    logic [7:0]        hi_byte;

    // One-word look-ahead so the last word of a line can be marked at href fall.
    logic              pend_valid;
    logic [15:0]       pend_data;
    logic              pend_sof;

    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  line_cnt;

    // A word released from the look-ahead stage toward the output register.
    logic              fire;
    logic [15:0]       fire_data;
    logic              fire_sof;
    logic              fire_eol;

    logic              err_ovf;
    logic              err_line;
    logic              err_frame;

    // Two-flop synchronizers for all camera inputs, plus the pclk edge history flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pclk_s  <= 3'b000;
            vsync_s <= 2'b00;
            href_s  <= 2'b00;
            data_s1 <= 8'h00;
            data_s2 <= 8'h00;
        end else begin
            pclk_s  <= {pclk_s[1:0], cam_pclk};
            vsync_s <= {vsync_s[0], cam_vsync};
            href_s  <= {href_s[0], cam_href};
            data_s1 <= cam_data;
            data_s2 <= data_s1;
        end
    end

    assign pe        = pclk_s[1] & ~pclk_s[2];
    assign vsync_now = vsync_s[1];
    assign href_now  = href_s[1];
    assign vs_rise   = pe & vsync_now & ~vs_q;
    assign vs_fall   = pe & ~vsync_now & vs_q;
    assign href_fall = pe & ~href_now & href_q;

    // Frame/line sequencing, byte packing, look-ahead and geometry measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_CFG;
            skip_cnt    <= SKIP_INIT;
            sof_pending <= 1'b0;
            phase       <= 1'b0;
            hi_byte     <= 8'h00;
            pend_valid  <= 1'b0;
            pend_data   <= 16'h0000;
            pend_sof    <= 1'b0;
            word_cnt    <= '0;
            line_cnt    <= '0;
            fire        <= 1'b0;
            fire_data   <= 16'h0000;
            fire_sof    <= 1'b0;
            fire_eol    <= 1'b0;
            frame_end   <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            vs_q        <= 1'b0;
            href_q      <= 1'b0;
        end else begin
            fire      <= 1'b0;
            frame_end <= 1'b0;
            if (pe) begin
                vs_q   <= vsync_now;
                href_q <= href_now;
            end
            if (!cfg_done) begin
                // Losing configuration abandons the frame; the sensor must settle again.
                state       <= WAIT_CFG;
                skip_cnt    <= SKIP_INIT;
                sof_pending <= 1'b0;
                phase       <= 1'b0;
                pend_valid  <= 1'b0;
                word_cnt    <= '0;
                line_cnt    <= '0;
            end else begin
                case (state)
                    WAIT_CFG: state <= WAIT_VS;
                    // Only start from blanking so a partial frame is never captured.
                    WAIT_VS: begin
                        if (pe && vsync_now) begin
                            state <= WAIT_SOF;
                        end
                    end
                    WAIT_SOF: begin
                        if (vs_fall) begin
                            if (skip_cnt != '0) begin
                                skip_cnt <= skip_cnt - SKIP_ONE;
                                state    <= SKIP;
                            end else begin
                                state       <= CAPTURE;
                                sof_pending <= 1'b1;
                                phase       <= 1'b0;
                                pend_valid  <= 1'b0;
                                word_cnt    <= '0;
                                line_cnt    <= '0;
                            end
                        end
                    end
                    SKIP: begin
                        if (vs_rise) begin
                            state <= WAIT_SOF;
                        end
                    end
                    CAPTURE: begin
                        if (pe && href_now) begin
                            phase <= ~phase;
                            if (!phase) begin
                                hi_byte <= data_s2;
                            end else begin
                                // A completed pair pushes the previous word out; the
                                // new word waits in case it is the last of the line.
                                if (pend_valid) begin
                                    fire      <= 1'b1;
                                    fire_data <= pend_data;
                                    fire_sof  <= pend_sof;
                                    fire_eol  <= 1'b0;
                                end
                                pend_valid  <= 1'b1;
                                pend_data   <= {hi_byte, data_s2};
                                pend_sof    <= sof_pending;
                                sof_pending <= 1'b0;
                                word_cnt    <= sat_inc(word_cnt);
                            end
                        end
                        if (href_fall) begin
                            // Line end: flush the held word as the last of the line;
                            // any unpaired byte is simply forgotten.
                            if (pend_valid) begin
                                fire      <= 1'b1;
                                fire_data <= pend_data;
                                fire_sof  <= pend_sof;
                                fire_eol  <= 1'b1;
                            end
                            pend_valid <= 1'b0;
                            phase      <= 1'b0;
                            meas_width <= word_cnt;
                            if (word_cnt != H_PIX_C || phase) begin
                                err_line <= 1'b1;
                            end
                            word_cnt <= '0;
                            line_cnt <= sat_inc(line_cnt);
                        end
                        if (vs_rise) begin
                            frame_end   <= 1'b1;
                            meas_height <= line_cnt;
                            if (line_cnt != V_LINES_C) begin
                                err_frame <= 1'b1;
                            end
                            line_cnt <= '0;
                            state    <= WAIT_SOF;
                        end
                    end
                    default: state <= WAIT_CFG;
                endcase
            end
        end
    end

    // Single-entry output holding register; a word arriving while full and stalled is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= 16'h0000;
            out_if.out_sof   <= 1'b0;
            out_if.out_eol   <= 1'b0;
            err_ovf          <= 1'b0;
        end else if (!cfg_done) begin
            out_if.out_valid <= 1'b0;
        end else if (fire) begin
            if (out_if.out_valid && !out_if.out_ready) begin
                err_ovf <= 1'b1;
            end else begin
                out_if.out_valid <= 1'b1;
                out_if.out_data  <= fire_data;
                out_if.out_sof   <= fire_sof;
                out_if.out_eol   <= fire_eol;
            end
        end else if (out_if.out_valid && out_if.out_ready) begin
            out_if.out_valid <= 1'b0;
        end
    end

    assign err_flags = {err_frame, err_line, err_ovf};
    assign state_dbg = state;

endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture with a reduced frame geometry. Camera timing is generated
// with a pclk of four system clocks; frames are random pixel bytes. The expected
// word stream ({sof, eol, data}) is built per line from the bytes sent and the
// frame-skip rule, and a monitor pops it on every accepted word.
module tb_dvp_capture;
    localparam int SKIP  = 2;
    localparam int H     = 6;
    localparam int V     = 4;
    localparam int CNT_W = 11;
    localparam int W     = 18;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_done;
    logic             cam_pclk;
    logic             cam_vsync;
    logic             cam_href;
    logic [7:0]       cam_data;
    logic             frame_end;
    logic [CNT_W-1:0] meas_width;
    logic [CNT_W-1:0] meas_height;
    logic [2:0]       err_flags;
    logic [2:0]       state_dbg;

    dvp_capture_if out_if ();

    dvp_capture #(
        .SKIP_FRAMES(SKIP),
        .H_PIX      (H),
        .V_LINES    (V),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_done   (cfg_done),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .out_if     (out_if),
        .frame_end  (frame_end),
        .meas_width (meas_width),
        .meas_height(meas_height),
        .err_flags  (err_flags),
        .state_dbg  (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;
    int n_sof = 0;
    int n_eol = 0;
    int fe_cnt = 0;
    bit seen_valid = 1'b0;
    int ready_mode = 0;
    int low_run = 0;
    bit sof_next = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer ready: random with at most two low cycles in a row, or forced.
    initial begin
        out_if.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #3;
            if (ready_mode == 1) begin
                out_if.out_ready = 1'b0;
            end else if (ready_mode == 2) begin
                out_if.out_ready = 1'b1;
            end else begin
                if (low_run >= 2) out_if.out_ready = 1'b1;
                else out_if.out_ready = ($urandom_range(0, 3) != 0);
                low_run = out_if.out_ready ? 0 : low_run + 1;
            end
        end
    end

    // Monitor / scoreboard: a transfer happens on the edge after a negedge sample
    // showing valid && ready.
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (out_if.out_valid === 1'b1) seen_valid = 1'b1;
            if (frame_end === 1'b1) fe_cnt++;
            if (out_if.out_valid === 1'b1 && out_if.out_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got %0h expected none", out_if.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_if.out_sof, out_if.out_eol, out_if.out_data} !== e) begin
                        n_err++;
                        $display("FAIL word: got sof=%0b eol=%0b data=%h expected sof=%0b eol=%0b data=%h",
                                 out_if.out_sof, out_if.out_eol, out_if.out_data, e[17], e[16], e[15:0]);
                    end
                end
                n_acc++;
                if (out_if.out_sof === 1'b1) n_sof++;
                if (out_if.out_eol === 1'b1) n_eol++;
            end
        end
    end

    // Watchdog.
    initial begin
        #2000000;
        n_err++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

    // One pclk period: low for two clks (inputs change here), then high for two.
    task automatic pclk_cycle(input logic [7:0] d, input logic hr, input logic vs);
        @(negedge clk);
        cam_pclk  = 1'b0;
        cam_data  = d;
        cam_href  = hr;
        cam_vsync = vs;
        @(negedge clk);
        @(negedge clk);
        cam_pclk = 1'b1;
        @(negedge clk);
    endtask

    // One line of random bytes followed by href low. Words are byte pairs, the last
    // complete pair carries eol, an unpaired final byte produces nothing.
    // lat: first pair is A5,3C and the output latency is measured on byte 3.
    // stall: consumer is held off until byte 8 has been sent; the first word is held,
    // words 1 and 2 complete while it is still held and are lost.
    task automatic send_line(input int nbytes, input bit cap, input bit lat, input bit stall);
        logic [7:0] b[$];
        int nw;
        b = {};
        for (int i = 0; i < nbytes; i++) b.push_back(8'($urandom_range(0, 255)));
        if (lat) begin
            b[0] = 8'hA5;
            b[1] = 8'h3C;
        end
        nw = nbytes / 2;
        if (cap) begin
            for (int i = 0; i < nw; i++) begin
                if (!(stall && (i == 1 || i == 2))) begin
                    exp_q.push_back({sof_next, (i == nw - 1), b[2*i], b[2*i+1]});
                    sof_next = 1'b0;
                end
            end
        end
        if (stall) ready_mode = 1;
        for (int i = 0; i < nbytes; i++) begin
            if (lat && i == 3) begin
                @(negedge clk);
                cam_pclk  = 1'b0;
                cam_data  = b[3];
                cam_href  = 1'b1;
                cam_vsync = 1'b0;
                @(negedge clk);
                @(negedge clk);
                cam_pclk = 1'b1;
                repeat (3) @(posedge clk);
                #1 check("lat_early_valid", 32'(out_if.out_valid), 32'd0);
                @(posedge clk);
                #1 check("lat_valid", 32'(out_if.out_valid), 32'd1);
                check("lat_data", 32'(out_if.out_data), 32'h0000A53C);
            end else begin
                pclk_cycle(b[i], 1'b1, 1'b0);
            end
            if (stall && i == 8) begin
                check("stall_hold_valid", 32'(out_if.out_valid), 32'd1);
                check("stall_hold_data", 32'(out_if.out_data), 32'({b[0], b[1]}));
                check("stall_ovf_flag", 32'(err_flags[0]), 32'd1);
                ready_mode = 2;
            end
        end
        pclk_cycle(8'h00, 1'b0, 1'b0);
        pclk_cycle(8'h00, 1'b0, 1'b0);
    endtask

    // Frame: vsync high (ends the previous frame), vsync low, lines, trailing gap.
    task automatic send_frame(input bit cap, input int nlines, input bit odd_last,
                              input bit lat, input bit stall);
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
        if (cap) sof_next = 1'b1;
        repeat (2) pclk_cycle(8'h00, 1'b0, 1'b0);
        for (int l = 0; l < nlines; l++) begin
            send_line((odd_last && l == nlines - 1) ? 2*H - 1 : 2*H, cap,
                      lat && l == 0, stall && l == 0);
        end
        repeat (2) pclk_cycle(8'h00, 1'b0, 1'b0);
        if (stall) ready_mode = 0;
    endtask

    task automatic send_idle();
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int acc0;
        int fe0;
        logic [7:0] a0;
        logic [7:0] a1;

        rst_n     = 1'b0;
        cfg_done  = 1'b0;
        cam_pclk  = 1'b0;
        cam_vsync = 1'b0;
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_if.out_valid), 32'd0);
        check("rst_data", 32'(out_if.out_data), 32'd0);
        check("rst_sof", 32'(out_if.out_sof), 32'd0);
        check("rst_eol", 32'(out_if.out_eol), 32'd0);
        check("rst_frame_end", 32'(frame_end), 32'd0);
        check("rst_meas_width", 32'(meas_width), 32'd0);
        check("rst_meas_height", 32'(meas_height), 32'd0);
        check("rst_err", 32'(err_flags), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;

        // Configuration not done: frames are ignored.
        repeat (2) send_frame(1'b0, V, 1'b0, 1'b0, 1'b0);
        send_idle();
        check("nocfg_seen_valid", 32'(seen_valid), 32'd0);
        check("nocfg_state", 32'(state_dbg), 32'd0);
        check("nocfg_frame_end", 32'(fe_cnt), 32'd0);

        // Configuration done: settling frames skipped, the rest captured.
        cfg_done = 1'b1;
        for (int f = 0; f < 4; f++) send_frame(f >= SKIP, V, 1'b0, 1'b0, 1'b0);
        send_idle();
        check("cap_words", 32'(n_acc), 32'(2*H*V));
        check("cap_sof", 32'(n_sof), 32'd2);
        check("cap_eol", 32'(n_eol), 32'(2*V));
        check("cap_frames", 32'(fe_cnt), 32'd2);
        check("cap_queue_empty", 32'(exp_q.size()), 32'd0);
        check("cap_meas_width", 32'(meas_width), 32'(H));
        check("cap_meas_height", 32'(meas_height), 32'(V));
        check("cap_err", 32'(err_flags), 32'd0);

        // Known first pair and output latency.
        send_frame(1'b1, V, 1'b0, 1'b1, 1'b0);
        // Backpressure on the first line.
        send_frame(1'b1, V, 1'b0, 1'b0, 1'b1);
        send_idle();
        check("stall_err", 32'(err_flags), 32'b001);
        check("stall_frames", 32'(fe_cnt), 32'd4);
        check("stall_meas_height", 32'(meas_height), 32'(V));

        // Short line with an odd trailing byte.
        send_frame(1'b1, V, 1'b1, 1'b0, 1'b0);
        send_idle();
        check("odd_meas_width", 32'(meas_width), 32'(H - 1));
        check("odd_meas_height", 32'(meas_height), 32'(V));
        check("odd_err", 32'(err_flags), 32'b011);

        // Short frame.
        send_frame(1'b1, V - 1, 1'b0, 1'b0, 1'b0);
        send_idle();
        check("short_meas_height", 32'(meas_height), 32'(V - 1));
        check("short_meas_width", 32'(meas_width), 32'(H));
        check("short_err", 32'(err_flags), 32'b111);
        check("short_queue_empty", 32'(exp_q.size()), 32'd0);

        // Configuration lost mid-line while a word is held.
        repeat (3) pclk_cycle(8'h00, 1'b0, 1'b1);
        repeat (2) pclk_cycle(8'h00, 1'b0, 1'b0);
        ready_mode = 1;
        a0 = 8'($urandom_range(0, 255));
        a1 = 8'($urandom_range(0, 255));
        pclk_cycle(a0, 1'b1, 1'b0);
        pclk_cycle(a1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) pclk_cycle(8'($urandom_range(0, 255)), 1'b1, 1'b0);
        check("drop_pre_valid", 32'(out_if.out_valid), 32'd1);
        check("drop_pre_data", 32'(out_if.out_data), 32'({a0, a1}));
        check("drop_pre_state", 32'(state_dbg), 32'd4);
        cfg_done = 1'b0;
        @(negedge clk);
        check("drop_valid", 32'(out_if.out_valid), 32'd0);
        check("drop_state", 32'(state_dbg), 32'd0);
        pclk_cycle(8'h00, 1'b0, 1'b0);
        ready_mode = 0;
        send_idle();
        cfg_done = 1'b1;
        acc0 = n_acc;
        fe0  = fe_cnt;
        for (int f = 0; f < 3; f++) send_frame(f >= SKIP, V, 1'b0, 1'b0, 1'b0);
        send_idle();
        check("recfg_words", 32'(n_acc - acc0), 32'(H*V));
        check("recfg_frames", 32'(fe_cnt - fe0), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_err", 32'(err_flags), 32'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
